// File: rtl/ooo_writeback_arbiter.sv
// Writeback stage: one holding register per FU result channel, round-robin granted onto NUM_WB CB write ports.
// Optional OOO_WB_STARVE_PRIO_EN adds per-entry wait counters that give long-waiting entries priority.
module ooo_writeback_arbiter #(
    parameter int NUM_FU       = 4,
    parameter int NUM_WB       = 2,
    parameter int CB_IDX_W     = 4,
    parameter int XLEN         = 32,
    parameter int REG_W        = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic                                flush,
    input  logic                                cb_stall,
    input  logic [NUM_FU-1:0]                   fu_valid,
    output logic [NUM_FU-1:0]                   fu_ready,
    input  logic [NUM_FU*CB_IDX_W-1:0]          fu_index,
    input  logic [NUM_FU*XLEN-1:0]              fu_wdata,
    input  logic [NUM_FU*XLEN-1:0]              fu_pc,
    input  logic [NUM_FU*REG_W-1:0]             fu_vd,
    input  logic [NUM_FU-1:0]                   fu_exception,
    output logic [NUM_WB-1:0]                   wb_valid,
    output logic [NUM_WB*CB_IDX_W-1:0]          wb_index,
    output logic [NUM_WB*XLEN-1:0]              wb_wdata,
    output logic [NUM_WB*REG_W-1:0]             wb_vd,
    output logic [NUM_WB-1:0]                   wb_exception,
    output logic [NUM_WB*$clog2(NUM_FU)-1:0]    wb_src
);

    localparam int SRC_W = $clog2(NUM_FU);

    if (NUM_FU < 2 || NUM_WB < 1 || NUM_WB > NUM_FU || STARVE_LIMIT < 1) begin : g_bad_params
        $error("ooo_writeback_arbiter: illegal parameter combination");
    end

    logic [NUM_FU-1:0]   occ;
    logic [CB_IDX_W-1:0] h_index [NUM_FU];
    logic [XLEN-1:0]     h_wdata [NUM_FU];
    logic [XLEN-1:0]     h_pc    [NUM_FU];
    logic [REG_W-1:0]    h_vd    [NUM_FU];
    logic [NUM_FU-1:0]   h_exc;

    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    rr_next;
    logic [NUM_FU-1:0]   grant;
    logic [NUM_FU-1:0]   load;
    logic [SRC_W-1:0]    sel   [NUM_WB];
    logic [NUM_WB-1:0]   sel_v;
    int                  nsel;

`ifdef OOO_WB_STARVE_PRIO_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

    logic [CNT_W-1:0]    wait_cnt [NUM_FU];
    logic [NUM_FU-1:0]   starving;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            starving[i] = occ[i] && (wait_cnt[i] >= CNT_W'(STARVE_LIMIT));
        end
    end

    // Wait counter saturates at all-ones so a long stall cannot wrap it back below the limit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_FU; i++) wait_cnt[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (load[i] || grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (occ[i] && (wait_cnt[i] != '1)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end
`endif

    // Grants fill ports in order: starving entries first (when enabled), then a round-robin scan from rr_ptr.
    always_comb begin
        grant   = '0;
        sel_v   = '0;
        rr_next = rr_ptr;
        nsel    = 0;
        for (int k = 0; k < NUM_WB; k++) sel[k] = '0;
        if (!cb_stall && !flush) begin
`ifdef OOO_WB_STARVE_PRIO_EN
            for (int i = 0; i < NUM_FU; i++) begin
                if (starving[i] && nsel < NUM_WB) begin
                    grant[i] = 1'b1;
                    for (int k = 0; k < NUM_WB; k++) begin
                        if (k == nsel) begin
                            sel[k]   = SRC_W'(i);
                            sel_v[k] = 1'b1;
                        end
                    end
                    nsel = nsel + 1;
                end
            end
`endif
            for (int j = 0; j < NUM_FU; j++) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (i == (int'(rr_ptr) + j) % NUM_FU && occ[i] && !grant[i] && nsel < NUM_WB) begin
                        grant[i] = 1'b1;
                        for (int k = 0; k < NUM_WB; k++) begin
                            if (k == nsel) begin
                                sel[k]   = SRC_W'(i);
                                sel_v[k] = 1'b1;
                            end
                        end
                        nsel    = nsel + 1;
                        rr_next = SRC_W'((i + 1) % NUM_FU);
                    end
                end
            end
        end
    end

    always_comb begin
        wb_valid     = '0;
        wb_index     = '0;
        wb_wdata     = '0;
        wb_vd        = '0;
        wb_exception = '0;
        wb_src       = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (sel_v[k]) begin
                wb_valid[k]                       = 1'b1;
                wb_index[k*CB_IDX_W +: CB_IDX_W]  = h_index[sel[k]];
                wb_wdata[k*XLEN +: XLEN]          = h_exc[sel[k]] ? h_pc[sel[k]] : h_wdata[sel[k]];
                wb_vd[k*REG_W +: REG_W]           = h_vd[sel[k]];
                wb_exception[k]                   = h_exc[sel[k]];
                wb_src[k*SRC_W +: SRC_W]          = sel[k];
            end
        end
    end

    // A granted entry can be refilled in the same cycle, giving one result per cycle per FU.
    assign fu_ready = flush ? '0 : (~occ | grant);
    assign load     = fu_valid & fu_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            occ    <= '0;
            rr_ptr <= '0;
            h_exc  <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                h_index[i] <= '0;
                h_wdata[i] <= '0;
                h_pc[i]    <= '0;
                h_vd[i]    <= '0;
            end
        end else if (flush) begin
            occ <= '0;
        end else begin
            occ    <= (occ & ~grant) | load;
            rr_ptr <= rr_next;
            for (int i = 0; i < NUM_FU; i++) begin
                if (load[i]) begin
                    h_index[i] <= fu_index[i*CB_IDX_W +: CB_IDX_W];
                    h_wdata[i] <= fu_wdata[i*XLEN +: XLEN];
                    h_pc[i]    <= fu_pc[i*XLEN +: XLEN];
                    h_vd[i]    <= fu_vd[i*REG_W +: REG_W];
                    h_exc[i]   <= fu_exception[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ooo_writeback_arbiter.sv
// Randomized and directed bench for ooo_writeback_arbiter against a queue-based behavioural model.
module tb_ooo_writeback_arbiter;

    localparam int NUM_FU       = 4;
    localparam int NUM_WB       = 2;
    localparam int CB_IDX_W     = 4;
    localparam int XLEN         = 32;
    localparam int REG_W        = 5;
    localparam int STARVE_LIMIT = 8;
    localparam int SRC_W        = $clog2(NUM_FU);
    localparam int CNT_MAX      = (1 << ($clog2(STARVE_LIMIT) + 1)) - 1;

    logic                        CLK = 1'b0;
    logic                        nRST = 1'b0;
    logic                        flush = 1'b0;
    logic                        cb_stall = 1'b0;
    logic [NUM_FU-1:0]           fu_valid = '0;
    logic [NUM_FU-1:0]           fu_ready;
    logic [NUM_FU*CB_IDX_W-1:0]  fu_index = '0;
    logic [NUM_FU*XLEN-1:0]      fu_wdata = '0;
    logic [NUM_FU*XLEN-1:0]      fu_pc = '0;
    logic [NUM_FU*REG_W-1:0]     fu_vd = '0;
    logic [NUM_FU-1:0]           fu_exception = '0;
    logic [NUM_WB-1:0]           wb_valid;
    logic [NUM_WB*CB_IDX_W-1:0]  wb_index;
    logic [NUM_WB*XLEN-1:0]      wb_wdata;
    logic [NUM_WB*REG_W-1:0]     wb_vd;
    logic [NUM_WB-1:0]           wb_exception;
    logic [NUM_WB*SRC_W-1:0]     wb_src;

    ooo_writeback_arbiter #(
        .NUM_FU(NUM_FU), .NUM_WB(NUM_WB), .CB_IDX_W(CB_IDX_W),
        .XLEN(XLEN), .REG_W(REG_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .cb_stall(cb_stall),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_index(fu_index),
        .fu_wdata(fu_wdata), .fu_pc(fu_pc), .fu_vd(fu_vd),
        .fu_exception(fu_exception), .wb_valid(wb_valid), .wb_index(wb_index),
        .wb_wdata(wb_wdata), .wb_vd(wb_vd), .wb_exception(wb_exception),
        .wb_src(wb_src)
    );

    always #5 CLK = ~CLK;

    bit                  m_occ   [NUM_FU];
    logic [CB_IDX_W-1:0] m_idx   [NUM_FU];
    logic [XLEN-1:0]     m_wdata [NUM_FU];
    logic [XLEN-1:0]     m_pc    [NUM_FU];
    logic [REG_W-1:0]    m_vd    [NUM_FU];
    bit                  m_exc   [NUM_FU];
    int                  m_wait  [NUM_FU];
    bit                  m_gr    [NUM_FU];
    int                  m_ptr;
    int                  gq[$];
    int                  rr_last;
    int                  checks = 0;
    int                  failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_FU; i++) begin
            m_occ[i] = 0; m_wait[i] = 0; m_gr[i] = 0;
        end
        m_ptr = 0;
    endfunction

    // Ordered list of granted FUs: starving ones (feature only) then round-robin from the pointer.
    function automatic void model_grants();
        gq.delete();
        rr_last = -1;
        for (int i = 0; i < NUM_FU; i++) m_gr[i] = 0;
        if (!cb_stall && !flush) begin
`ifdef OOO_WB_STARVE_PRIO_EN
            for (int i = 0; i < NUM_FU; i++) begin
                if (m_occ[i] && m_wait[i] >= STARVE_LIMIT && gq.size() < NUM_WB) begin
                    gq.push_back(i); m_gr[i] = 1;
                end
            end
`endif
            for (int j = 0; j < NUM_FU; j++) begin
                int f;
                f = (m_ptr + j) % NUM_FU;
                if (m_occ[f] && !m_gr[f] && gq.size() < NUM_WB) begin
                    gq.push_back(f); m_gr[f] = 1; rr_last = f;
                end
            end
        end
    endfunction

    task automatic check_cycle();
        logic [NUM_FU-1:0] exp_ready;
        model_grants();
        for (int k = 0; k < NUM_WB; k++) begin
            logic            ev;
            logic [63:0]     ei, ed, evd, ee, es;
            ev = 0; ei = 0; ed = 0; evd = 0; ee = 0; es = 0;
            if (k < gq.size()) begin
                int g;
                g = gq[k];
                ev = 1; ei = 64'(m_idx[g]); evd = 64'(m_vd[g]); ee = 64'(m_exc[g]); es = 64'(g);
                ed = m_exc[g] ? 64'(m_pc[g]) : 64'(m_wdata[g]);
            end
            checkOutput($sformatf("wb_valid[%0d]", k), 64'(wb_valid[k]), 64'(ev));
            checkOutput($sformatf("wb_index[%0d]", k), 64'(wb_index[k*CB_IDX_W +: CB_IDX_W]), ei);
            checkOutput($sformatf("wb_wdata[%0d]", k), 64'(wb_wdata[k*XLEN +: XLEN]), ed);
            checkOutput($sformatf("wb_vd[%0d]", k), 64'(wb_vd[k*REG_W +: REG_W]), evd);
            checkOutput($sformatf("wb_exception[%0d]", k), 64'(wb_exception[k]), ee);
            checkOutput($sformatf("wb_src[%0d]", k), 64'(wb_src[k*SRC_W +: SRC_W]), es);
        end
        for (int i = 0; i < NUM_FU; i++) exp_ready[i] = !flush && (!m_occ[i] || m_gr[i]);
        checkOutput("fu_ready", 64'(fu_ready), 64'(exp_ready));
    endtask

    function automatic void model_update();
        if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                m_occ[i] = 0; m_wait[i] = 0;
            end
            return;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && (!m_occ[i] || m_gr[i])) begin
                m_occ[i]   = 1;
                m_wait[i]  = 0;
                m_idx[i]   = fu_index[i*CB_IDX_W +: CB_IDX_W];
                m_wdata[i] = fu_wdata[i*XLEN +: XLEN];
                m_pc[i]    = fu_pc[i*XLEN +: XLEN];
                m_vd[i]    = fu_vd[i*REG_W +: REG_W];
                m_exc[i]   = fu_exception[i];
            end else if (m_gr[i]) begin
                m_occ[i]  = 0;
                m_wait[i] = 0;
            end else if (m_occ[i] && m_wait[i] < CNT_MAX) begin
                m_wait[i] = m_wait[i] + 1;
            end
        end
        if (rr_last >= 0) m_ptr = (rr_last + 1) % NUM_FU;
    endfunction

    task automatic applyStimulus(input logic [NUM_FU-1:0] v, input logic stall, input logic fl);
        @(posedge CLK);
        #1;
        fu_valid = v; cb_stall = stall; flush = fl;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_index[i*CB_IDX_W +: CB_IDX_W] = CB_IDX_W'($urandom);
            fu_wdata[i*XLEN +: XLEN]         = XLEN'($urandom);
            fu_pc[i*XLEN +: XLEN]            = XLEN'($urandom);
            fu_vd[i*REG_W +: REG_W]          = REG_W'($urandom);
            fu_exception[i]                  = 1'($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic set_fu(input int i, input logic [CB_IDX_W-1:0] idx, input logic [XLEN-1:0] wd,
                          input logic [XLEN-1:0] pc, input logic [REG_W-1:0] vd, input logic exc);
        fu_index[i*CB_IDX_W +: CB_IDX_W] = idx;
        fu_wdata[i*XLEN +: XLEN]         = wd;
        fu_pc[i*XLEN +: XLEN]            = pc;
        fu_vd[i*REG_W +: REG_W]          = vd;
        fu_exception[i]                  = exc;
    endtask

    task automatic end_cycle();
        #2;
        check_cycle();
        model_update();
    endtask

    // Reset is asserted mid-cycle so outputs must clear without waiting for an edge.
    task automatic do_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        fu_valid = '0; cb_stall = 1'b0; flush = 1'b0;
        #1;
        checkOutput("async_reset wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("async_reset wb_wdata", 64'(wb_wdata), 64'd0);
        checkOutput("async_reset wb_src", 64'(wb_src), 64'd0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        nRST = 1'b1;

        applyStimulus('0, 0, 0); end_cycle();
        checkOutput("reset fu_ready", 64'(fu_ready), 64'hF);
        checkOutput("reset wb_valid", 64'(wb_valid), 64'd0);

        applyStimulus(4'b0100, 0, 0);
        set_fu(2, 4'd3, 32'hDEAD_BEEF, 32'h0000_1000, 5'd7, 1'b0);
        end_cycle();
        applyStimulus(4'b1001, 0, 0); end_cycle();
        checkOutput("single wb_valid", 64'(wb_valid), 64'b01);
        checkOutput("single wb_index", 64'(wb_index[3:0]), 64'd3);
        checkOutput("single wb_wdata", 64'(wb_wdata[31:0]), 64'hDEAD_BEEF);
        checkOutput("single wb_src", 64'(wb_src[1:0]), 64'd2);
        applyStimulus('0, 0, 0); end_cycle();
        checkOutput("rrptr3 wb_src", 64'(wb_src), 64'b0011);

        do_reset();
        applyStimulus(4'b1111, 0, 0); end_cycle();
        applyStimulus('0, 0, 0); end_cycle();
        checkOutput("oversub c1 wb_src", 64'(wb_src), 64'b0100);
        checkOutput("oversub c1 fu_ready", 64'(fu_ready), 64'b0011);
        applyStimulus('0, 0, 0); end_cycle();
        checkOutput("oversub c2 wb_src", 64'(wb_src), 64'b1110);
        checkOutput("oversub c2 wb_valid", 64'(wb_valid), 64'b11);

        applyStimulus(4'b0010, 0, 0);
        set_fu(1, 4'd9, 32'h55, 32'h0000_0200, 5'd3, 1'b1);
        end_cycle();
        applyStimulus('0, 0, 0); end_cycle();
        checkOutput("exc wb_wdata", 64'(wb_wdata[31:0]), 64'h200);
        checkOutput("exc wb_exception", 64'(wb_exception[0]), 64'd1);

        applyStimulus(4'b0001, 0, 0);
        set_fu(0, 4'd1, 32'h111, 32'h0, 5'd1, 1'b0);
        end_cycle();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0001, 1, 0);
            set_fu(0, 4'd2, 32'h222, 32'h0, 5'd2, 1'b0);
            end_cycle();
            checkOutput("stall wb_valid", 64'(wb_valid), 64'd0);
            checkOutput("stall fu_ready0", 64'(fu_ready[0]), 64'd0);
        end
        applyStimulus(4'b0001, 0, 0);
        set_fu(0, 4'd2, 32'h222, 32'h0, 5'd2, 1'b0);
        end_cycle();
        checkOutput("stall release first", 64'(wb_wdata[31:0]), 64'h111);
        applyStimulus('0, 0, 0); end_cycle();
        checkOutput("stall release second", 64'(wb_wdata[31:0]), 64'h222);

        applyStimulus(4'b0111, 1, 0); end_cycle();
        applyStimulus(4'b1111, 0, 1); end_cycle();
        checkOutput("flush wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("flush fu_ready", 64'(fu_ready), 64'd0);
        applyStimulus('0, 0, 0); end_cycle();
        checkOutput("post flush wb_valid", 64'(wb_valid), 64'd0);
        applyStimulus(4'b1001, 0, 0); end_cycle();
        applyStimulus('0, 0, 0); end_cycle();
        checkOutput("post flush wb_src", 64'(wb_src), 64'b0011);
        checkOutput("post flush wb_valid2", 64'(wb_valid), 64'b11);

        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset();
            applyStimulus(NUM_FU'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 19) == 0));
            end_cycle();
        end

        applyStimulus('0, 0, 0); end_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
